systolic_skew_feeder: RTL and testbench



---
 rtl/systolic_skew_feeder_if.sv | 24 ++
 rtl/systolic_skew_feeder.sv | 139 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_skew_feeder_if.sv
// k-step input stream into the skew feeder: one activation column and one weight row per beat.
interface systolic_skew_feeder_if #(
    parameter int unsigned SIZE       = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [SIZE*DATA_WIDTH-1:0] in_a;
    logic [SIZE*DATA_WIDTH-1:0] in_b;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        output in_ready
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Feeds the north/west edges of a SIZE x SIZE systolic array with triangular per-lane skew,
// sequences the tile (clear, stream, drain) and flags when the last product has landed.
module systolic_skew_feeder #(
    parameter int unsigned SIZE       = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned K_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [K_WIDTH-1:0]         k_len,
    systolic_skew_feeder_if.slave      bus,
    output logic [SIZE*DATA_WIDTH-1:0] west_inputs,
    output logic [SIZE*DATA_WIDTH-1:0] north_inputs,
    output logic [SIZE-1:0]            west_valid,
    output logic [SIZE-1:0]            north_valid,
    output logic                       accum_reset,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StDone
    } state_e;

    localparam logic [K_WIDTH-1:0] DrainLast = K_WIDTH'(2 * SIZE - 1);

    state_e             state_q;
    logic [K_WIDTH-1:0] k_len_q;
    logic [K_WIDTH-1:0] beat_cnt_q;
    logic [K_WIDTH-1:0] drain_cnt_q;
    logic               in_ready_q;
    logic               accept;
    logic [SIZE-1:0]    vld_sr_q;

    assign accept       = bus.in_valid & in_ready_q;
    assign bus.in_ready = in_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            accum_reset <= 1'b0;
        end else begin
            done        <= 1'b0;
            accum_reset <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        k_len_q     <= k_len;
                        beat_cnt_q  <= '0;
                        busy        <= 1'b1;
                        accum_reset <= 1'b1;
                        state_q     <= StClear;
                    end
                end
                StClear: begin
                    if (k_len_q == '0) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= StStream;
                    end
                end
                StStream: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + K_WIDTH'(1);
                        if (beat_cnt_q + K_WIDTH'(1) == k_len_q) begin
                            in_ready_q  <= 1'b0;
                            drain_cnt_q <= '0;
                            state_q     <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // 2*SIZE cycles covers the deepest lane plus the array diagonal
                    if (drain_cnt_q == DrainLast) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + K_WIDTH'(1);
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stage j of this register holds the accept flag delayed j+1 cycles; shared by both edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q <= {vld_sr_q[SIZE-2:0], accept};
        end
    end

    assign west_valid  = vld_sr_q;
    assign north_valid = vld_sr_q;

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_sr_q [i+1];
        logic [DATA_WIDTH-1:0] b_sr_q [i+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    a_sr_q[j] <= '0;
                    b_sr_q[j] <= '0;
                end
            end else begin
                a_sr_q[0] <= accept ? bus.in_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                b_sr_q[0] <= accept ? bus.in_b[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int j = 1; j <= i; j++) begin
                    a_sr_q[j] <= a_sr_q[j-1];
                    b_sr_q[j] <= b_sr_q[j-1];
                end
            end
        end

        assign west_inputs[i*DATA_WIDTH +: DATA_WIDTH]  = vld_sr_q[i] ? a_sr_q[i] : '0;
        assign north_inputs[i*DATA_WIDTH +: DATA_WIDTH] = vld_sr_q[i] ? b_sr_q[i] : '0;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder with a behavioural 16x16 MAC array on its edges.
module tb_systolic_skew_feeder;
    localparam int SIZE = 16;
    localparam int DW   = 8;
    localparam int KW   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic [SIZE*DW-1:0]   west_inputs, north_inputs;
    logic [SIZE-1:0]      west_valid, north_valid;
    logic                 accum_reset, busy, done;

    systolic_skew_feeder_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) bus ();

    systolic_skew_feeder #(.SIZE(SIZE), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .bus          (bus),
        .west_inputs  (west_inputs),
        .north_inputs (north_inputs),
        .west_valid   (west_valid),
        .north_valid  (north_valid),
        .accum_reset  (accum_reset),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    bit chk_result = 1'b0;

    // Expected lane entries: {cycle[31:0], a[7:0], b[7:0]}
    logic [47:0] lane_q [SIZE][$];
    int          done_q [$];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, idx, cyc, act, act, exp, exp);
        end
    endtask

    // Behavioural systolic array: a flows east, b flows south, each PE accumulates a*b.
    logic signed [DW-1:0] pa [SIZE][SIZE];
    logic signed [DW-1:0] pb [SIZE][SIZE];
    logic signed [31:0]   acc [SIZE][SIZE];

    always @(posedge clk) begin
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                pa[r][c]  <= (c == 0) ? west_inputs[r*DW +: DW] : pa[r][c-1];
                pb[r][c]  <= (r == 0) ? north_inputs[c*DW +: DW] : pb[r-1][c];
                acc[r][c] <= accum_reset ? 32'sd0 : acc[r][c] + pa[r][c] * pb[r][c];
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int i = 0; i < SIZE; i++) begin
                logic [47:0] e;
                check("valid_match", i, 32'(north_valid[i]), 32'(west_valid[i]));
                if (west_valid[i] === 1'b1) begin
                    if (lane_q[i].size() == 0) begin
                        check("unexpected_valid", i, 32'(1), 32'(0));
                    end else begin
                        e = lane_q[i].pop_front();
                        check("lane_cycle", i, cyc, e[47:16]);
                        check("west_data", i, 32'(west_inputs[i*DW +: DW]), 32'(e[15:8]));
                        check("north_data", i, 32'(north_inputs[i*DW +: DW]), 32'(e[7:0]));
                    end
                end else if (west_inputs[i*DW +: DW] !== '0 ||
                             north_inputs[i*DW +: DW] !== '0) begin
                    check("idle_data_zero", i, 32'({west_inputs[i*DW +: DW],
                          north_inputs[i*DW +: DW]}), 32'(0));
                end
            end
            if (accum_reset === 1'b1) check("clear_while_valid", 0, 32'(west_valid), 32'(0));
            if (done === 1'b1) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    check("unexpected_done", 0, 32'(1), 32'(0));
                end else begin
                    check("done_cycle", 0, cyc, done_q.pop_front());
                    if (chk_result) begin
                        for (int r = 0; r < SIZE; r++) begin
                            for (int c = 0; c < SIZE; c++) begin
                                logic signed [7:0] e8;
                                e8 = 8'(r * 16 + c);
                                check("result", r * SIZE + c, acc[r][c], 32'(int'(e8)));
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane_val(input int kind, input int side, input int k,
                                            input int lane);
        case (kind)
            0:       return (side == 0) ? 8'(lane + 1) : 8'd2;
            1:       return (side == 0) ? ((lane == k) ? 8'd1 : 8'd0) : 8'(k * 16 + lane);
            default: return (side == 0) ? 8'(k * 37 + lane * 5 + 3) : (8'hA5 ^ 8'(k * 16 + lane));
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 0, 32'(bus.in_ready), 32'(0));
        check({tag, "_busy"}, 0, 32'(busy), 32'(0));
        check({tag, "_done"}, 0, 32'(done), 32'(0));
        check({tag, "_accum_reset"}, 0, 32'(accum_reset), 32'(0));
        check({tag, "_west_valid"}, 0, 32'(west_valid), 32'(0));
        check({tag, "_north_valid"}, 0, 32'(north_valid), 32'(0));
        check({tag, "_west_nz"}, 0, 32'(|west_inputs), 32'(0));
        check({tag, "_north_nz"}, 0, 32'(|north_inputs), 32'(0));
    endtask

    // Drive start for one cycle; returns in the CLEAR cycle.
    task automatic start_tile(input int k);
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
        check("clear_accum_reset", 0, 32'(accum_reset), 32'(1));
        check("clear_busy", 0, 32'(busy), 32'(1));
    endtask

    // Offers beats with `gap` idle cycles between offers; sends `send_n` of a `total` tile.
    task automatic run_stream(input int kind, input int total, input int send_n, input int gap,
                              input bit pulse_start);
        int beats = 0;
        int phase = 0;
        int guard = 0;
        while (beats < send_n && guard < 2000) begin
            bus.in_valid = (phase == 0);
            start        = pulse_start && (guard % 2 == 0);
            k_len        = pulse_start ? KW'(1) : k_len;
            for (int l = 0; l < SIZE; l++) begin
                bus.in_a[l*DW +: DW] = lane_val(kind, 0, beats, l);
                bus.in_b[l*DW +: DW] = lane_val(kind, 1, beats, l);
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int l = 0; l < SIZE; l++) begin
                    lane_q[l].push_back({32'(cyc + 1 + l), lane_val(kind, 0, beats, l),
                                         lane_val(kind, 1, beats, l)});
                end
                if (beats == total - 1) done_q.push_back(cyc + 2 * SIZE + 1);
                beats++;
            end
            phase = (phase == gap) ? 0 : phase + 1;
            guard++;
            tick();
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        if (guard >= 2000) check("stream_timeout", 0, 32'(beats), 32'(send_n));
        check("beats_accepted", 0, 32'(beats), 32'(send_n));
        if (beats == total) check("ready_drop", 0, 32'(bus.in_ready), 32'(0));
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("done_timeout", 0, 32'(done_q.size()), 32'(0));
        check("idle_after_done", 0, 32'(busy), 32'(0));
    endtask

    initial begin
        int s;
        int d0;
        rst          = 1'b1;
        start        = 1'b0;
        k_len        = '0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single beat
        start_tile(1);
        run_stream(0, 1, 1, 0, 1'b0);
        wait_done();
        tick();

        // Identity x B through the array
        chk_result = 1'b1;
        start_tile(16);
        run_stream(1, 16, 16, 0, 1'b0);
        wait_done();
        tick();

        // Same tile with bubbles (valid pattern 1,0,0,...)
        start_tile(16);
        run_stream(1, 16, 16, 2, 1'b0);
        wait_done();
        chk_result = 1'b0;
        tick();

        // k_len = 0
        s = cyc;
        done_q.push_back(s + 2);
        start_tile(0);
        tick();
        check("k0_accum_reset_off", 0, 32'(accum_reset), 32'(0));
        wait_done();
        check("k0_idle_cycle", 0, cyc, s + 3);
        tick();

        // Reset mid-stream after five beats
        start_tile(10);
        run_stream(2, 10, 5, 0, 1'b0);
        rst = 1'b1;
        for (int l = 0; l < SIZE; l++) lane_q[l].delete();
        done_q.delete();
        tick();
        rst = 1'b0;
        check_all_zero("midreset");
        d0 = done_seen;
        repeat (100) tick();
        check("no_done_after_reset", 0, 32'(done_seen - d0), 32'(0));
        start_tile(4);
        run_stream(2, 4, 4, 1, 1'b0);
        wait_done();
        tick();

        // start pulsed during STREAM and DRAIN
        d0 = done_seen;
        start_tile(6);
        run_stream(2, 6, 6, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            tick();
        end
        start = 1'b0;
        wait_done();
        repeat (40) tick();
        check("one_done", 0, 32'(done_seen - d0), 32'(1));

        for (int l = 0; l < SIZE; l++) check("lane_q_empty", l, 32'(lane_q[l].size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
